// File: rtl/result_bin2bcd.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).
// Optional `BCD_BLANK_EN: leading zeros become 4'hF and out_ndigits reports significant digits.
module result_bin2bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [3:0]            out_ndigits
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready depends on state only, and out_valid/out_bcd hold until accepted.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] shifted;
    logic [4*DIGITS-1:0] result_bcd;
    logic [CW-1:0]       cnt;

    // Digits >= 5 are corrected before the shift so they carry correctly into the next digit.
    always_comb begin
        adj = bcd_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    end

`ifdef BCD_BLANK_EN
    logic       seen;
    logic [3:0] ndig;

    // Blank zeros above the most significant nonzero digit; the units digit always shows.
    always_comb begin
        result_bcd = shifted;
        ndig       = 4'd1;
        seen       = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (!seen && shifted[4*d +: 4] == 4'd0) begin
                result_bcd[4*d +: 4] = 4'hF;
            end else if (!seen) begin
                seen = 1'b1;
                ndig = 4'(d + 1);
            end
        end
    end
`else
    assign result_bcd = shifted;
`endif

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            cnt       <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
`ifdef BCD_BLANK_EN
            out_ndigits <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_data;
                        bcd_sr <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted;
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        out_bcd   <= result_bcd;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef BCD_BLANK_EN
                        out_ndigits <= ndig;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bin2bcd.sv
// Bench for result_bin2bcd: decimal-arithmetic reference model, per-cycle compare process,
// directed cases plus randomized values with random backpressure.
module tb_result_bin2bcd;

    localparam int W = 32;
    localparam int D = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [4*D-1:0]   out_bcd;
`ifdef BCD_BLANK_EN
    logic [3:0]       out_ndigits;
`endif

    result_bin2bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
`ifdef BCD_BLANK_EN
        ,
        .out_ndigits (out_ndigits)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [4*D-1:0] exp_q[$];
    logic [3:0]     nd_q[$];
    int             rise_q[$];
    logic [4*D-1:0] last_bcd = '0;
    logic [3:0]     last_nd  = '0;
    bit             busy     = 1'b0;
    bit             prev_ov  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4*D-1:0] model_bcd(input longint unsigned v);
        logic [4*D-1:0] r;
        longint unsigned x;
        int top;
        r = '0;
        x = v;
        top = 0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            if (x % 10 != 0) top = i;
            x = x / 10;
        end
`ifdef BCD_BLANK_EN
        for (int i = top + 1; i < D; i++) r[4*i +: 4] = 4'hF;
`endif
        return r;
    endfunction

    function automatic logic [3:0] model_nd(input longint unsigned v);
        int n;
        longint unsigned x;
        n = 0;
        x = v;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        if (n == 0) n = 1;
        return 4'(n);
    endfunction

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("in_ready", {63'd0, in_ready}, {63'd0, !busy});
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_out_valid: got out_bcd %0h expected no output", out_bcd);
                    end else begin
                        if (!prev_ov) check("latency", 64'(cyc), 64'(rise_q[0]));
                        check("out_bcd", 64'(out_bcd), 64'(exp_q[0]));
`ifdef BCD_BLANK_EN
                        check("out_ndigits", 64'(out_ndigits), 64'(nd_q[0]));
`endif
                        if (out_ready) begin
                            last_bcd = exp_q.pop_front();
                            last_nd  = nd_q.pop_front();
                            void'(rise_q.pop_front());
                            busy = 1'b0;
                        end
                    end
                end else begin
                    check("out_bcd_hold", 64'(out_bcd), 64'(last_bcd));
`ifdef BCD_BLANK_EN
                    check("out_ndigits_hold", 64'(out_ndigits), 64'(last_nd));
`endif
                end
                if (in_valid && in_ready) begin
                    busy = 1'b1;
                    exp_q.push_back(model_bcd(longint'(in_data)));
                    nd_q.push_back(model_nd(longint'(in_data)));
                    rise_q.push_back(cyc + 33);
                end
                prev_ov = out_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        nd_q.delete();
        rise_q.delete();
        busy     = 1'b0;
        prev_ov  = 1'b0;
        last_bcd = '0;
        last_nd  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_bcd", 64'(out_bcd), 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef BCD_BLANK_EN
        check("rst_out_ndigits", 64'(out_ndigits), 64'd0);
`endif
    endtask

    task automatic send(input logic [W-1:0] v, input bit keep, output int acc_cyc);
        bit got;
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        in_data  = v;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!keep) in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept expected accept of %0d", v);
        end
    endtask

    task automatic wait_idle(input bit rand_bp);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            if (exp_q.size() == 0 && !busy) done = 1'b1;
            else begin
                out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_out_valid();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (out_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    // ---------------- expected literals ----------------
`ifdef BCD_BLANK_EN
    localparam logic [39:0] L_12F  = 40'hF479001600;
    localparam logic [39:0] L_ZERO = 40'hFFFFFFFFF0;
    localparam logic [39:0] L_10F  = 40'hFFF3628800;
    localparam logic [39:0] L_720  = 40'hFFFFFFF720;
`else
    localparam logic [39:0] L_12F  = 40'h0479001600;
    localparam logic [39:0] L_ZERO = 40'h0000000000;
    localparam logic [39:0] L_10F  = 40'h0003628800;
    localparam logic [39:0] L_720  = 40'h0000000720;
`endif

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got %0d cycles expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, a2, a3, acc;
        logic [W-1:0] v;

        // Pin the model with hand-computed values.
        check("model_12f", 64'(model_bcd(64'd479001600)), 64'(L_12F));
        check("model_zero", 64'(model_bcd(64'd0)), 64'(L_ZERO));
        check("model_max", 64'(model_bcd(64'd4294967295)), 64'h4294967295);
        check("model_nd_120", 64'(model_nd(64'd120)), 64'd3);
        check("model_nd_0", 64'(model_nd(64'd0)), 64'd1);
`ifdef BCD_BLANK_EN
        check("model_blank_120", 64'(model_bcd(64'd120)), 64'hFFFFFFF120);
`endif

        do_reset();

        send(32'd479001600, 1'b0, acc);
        wait_idle(1'b0);
        check("dut_12f", 64'(out_bcd), 64'(L_12F));

        send(32'd0, 1'b0, acc);
        wait_idle(1'b0);
        check("dut_zero", 64'(out_bcd), 64'(L_ZERO));
`ifdef BCD_BLANK_EN
        check("dut_nd_zero", 64'(out_ndigits), 64'd1);
`endif

        send(32'hFFFFFFFF, 1'b0, acc);
        wait_idle(1'b0);
        check("dut_max", 64'(out_bcd), 64'h4294967295);

`ifdef BCD_BLANK_EN
        send(32'd120, 1'b0, acc);
        wait_idle(1'b0);
        check("dut_blank_120", 64'(out_bcd), 64'hFFFFFFF120);
        check("dut_nd_120", 64'(out_ndigits), 64'd3);
`endif

        // Back-to-back with in_valid held high.
        send(32'd1, 1'b1, a0);
        send(32'd2, 1'b1, a1);
        send(32'd6, 1'b1, a2);
        send(32'd24, 1'b0, a3);
        wait_idle(1'b0);
        check("b2b_spacing_1", 64'(a1 - a0), 64'd34);
        check("b2b_spacing_2", 64'(a2 - a1), 64'd34);
        check("b2b_spacing_3", 64'(a3 - a2), 64'd34);

        // Backpressure with a competing request during the stall.
        out_ready = 1'b0;
        send(32'd3628800, 1'b0, acc);
        wait_out_valid();
        in_data  = 32'd12345;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("stall_bcd", 64'(out_bcd), 64'(L_10F));
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(1'b0);

        // Reset in the middle of a conversion.
        send(32'd5040, 1'b0, acc);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        send(32'd720, 1'b0, acc);
        wait_idle(1'b0);
        check("dut_720", 64'(out_bcd), 64'(L_720));

        // Randomized values under random backpressure.
        for (int i = 0; i < 25; i++) begin
            v = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 999)) : W'($urandom);
            send(v, 1'b0, acc);
            wait_idle(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
